// File: rtl/sliced_adder_if.sv
// Operand/result/handshake bundle for sliced_adder_unit.
// The V port exists only when SLICED_ADDER_OVF_EN is defined.
interface sliced_adder_if #(
    parameter int WIDTH = 16
);
    logic             LoadA;
    logic             LoadB;
    logic             Run;
    logic             Sub;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic [WIDTH-1:0] Sum;
    logic             CO;
    logic             Busy;
    logic             Done;
`ifdef SLICED_ADDER_OVF_EN
    logic             V;
`endif

    modport master (
`ifdef SLICED_ADDER_OVF_EN
        input  V,
`endif
        output LoadA, LoadB, Run, Sub, SW,
        input  A_out, B_out, Sum, CO, Busy, Done
    );

    modport slave (
`ifdef SLICED_ADDER_OVF_EN
        output V,
`endif
        input  LoadA, LoadB, Run, Sub, SW,
        output A_out, B_out, Sum, CO, Busy, Done
    );
endinterface

// File: rtl/sliced_adder_unit.sv
// Multi-cycle add/subtract, SLICE bits per clock with a registered inter-slice carry.
// Define SLICED_ADDER_OVF_EN to build the signed-overflow output V.
module sliced_adder_unit #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    sliced_adder_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] a_sl_s;
    logic [SLICE-1:0] b_sl_s;
    logic [SLICE:0]   slice_r_s;
    int unsigned      base_s;

`ifdef SLICED_ADDER_OVF_EN
    logic             v_q, v_d;
    logic             msb_cin_s;
`endif

    // Slice datapath and next-state / next-output decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        co_d    = co_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        mode_d  = mode_q;

        base_s    = 32'(idx_q) * 32'(SLICE);
        a_sl_s    = a_q[base_s +: SLICE];
        b_sl_s    = mode_q ? ~b_q[base_s +: SLICE] : b_q[base_s +: SLICE];
        slice_r_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, carry_q};
`ifdef SLICED_ADDER_OVF_EN
        v_d       = v_q;
        // Carry into the MSB is recovered from the MSB sum bit of the last slice.
        msb_cin_s = a_sl_s[SLICE-1] ^ b_sl_s[SLICE-1] ^ slice_r_s[SLICE-1];
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.LoadA) begin
                    a_d = bus.SW;
                end else begin
                    a_d = a_q;
                end
                if (bus.LoadB) begin
                    b_d = bus.SW;
                end else begin
                    b_d = b_q;
                end
                if (bus.Run) begin
                    state_d = S_CALC;
                    sum_d   = {WIDTH{1'b0}};
                    co_d    = 1'b0;
                    idx_d   = {IDXW{1'b0}};
                    carry_d = bus.Sub;
                    mode_d  = bus.Sub;
`ifdef SLICED_ADDER_OVF_EN
                    v_d     = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                sum_d[base_s +: SLICE] = slice_r_s[SLICE-1:0];
                carry_d                = slice_r_s[SLICE];
                if (idx_q == LAST_IDX) begin
                    co_d    = slice_r_s[SLICE];
                    idx_d   = {IDXW{1'b0}};
                    state_d = S_DONE;
`ifdef SLICED_ADDER_OVF_EN
                    v_d     = msb_cin_s ^ slice_r_s[SLICE];
`endif
                end else begin
                    idx_d   = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (bus.Run) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers, cleared asynchronously by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            co_q    <= 1'b0;
            idx_q   <= {IDXW{1'b0}};
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SLICED_ADDER_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SLICED_ADDER_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    assign bus.A_out = a_q;
    assign bus.B_out = b_q;
    assign bus.Sum   = sum_q;
    assign bus.CO    = co_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
`ifdef SLICED_ADDER_OVF_EN
    assign bus.V     = v_q;
`endif
endmodule

// File: tb/tb_sliced_adder_unit.sv
// Scoreboard bench for sliced_adder_unit: SLICE=4 main instance plus a SLICE=16 instance.
module tb_sliced_adder_unit;
    localparam int W = 16;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    sliced_adder_if #(.WIDTH(W)) bus ();
    sliced_adder_if #(.WIDTH(W)) bus16 ();

    sliced_adder_unit #(.WIDTH(W), .SLICE(4))  dut   (.Clk(Clk), .Reset(Reset), .bus(bus.slave));
    sliced_adder_unit #(.WIDTH(W), .SLICE(16)) dut16 (.Clk(Clk), .Reset(Reset), .bus(bus16.slave));

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   r;
        bb    = sub ? ~b : b;
        r     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        e.sum = r[W-1:0];
        e.co  = r[W];
        e.v   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.SW = a; bus.LoadA = 1'b1;
        tick();
        bus.LoadA = 1'b0; bus.SW = b; bus.LoadB = 1'b1;
        tick();
        bus.LoadB = 1'b0;
    endtask

    // Waits (bounded) for Done, then pops and compares one scoreboard entry.
    task automatic finish_op(input string name, input int exp_busy);
        int   busy_cnt = 1;
        int   guard = 0;
        exp_t e;
        while (bus.Done !== 1'b1 && guard < 40) begin
            tick();
            guard++;
            if (bus.Busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (bus.Done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: Done=%b after %0d cycles, required 1", name, bus.Done, guard);
        end
        checks++;
        if (busy_cnt != exp_busy || guard != exp_busy) begin
            errors++;
            $display("FAIL %s_latency: busy=%0d done_after=%0d, required %0d", name, busy_cnt, guard, exp_busy);
        end
        e = sb.pop_front();
        checks++;
        if (bus.Sum !== e.sum || bus.CO !== e.co) begin
            errors++;
            $display("FAIL %s_result: Sum=%h CO=%b, required Sum=%h CO=%b", name, bus.Sum, bus.CO, e.sum, e.co);
        end
`ifdef SLICED_ADDER_OVF_EN
        checks++;
        if (bus.V !== e.v) begin
            errors++;
            $display("FAIL %s_v: V=%b, required %b", name, bus.V, e.v);
        end
`endif
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input string name);
        load_ops(a, b);
        checks++;
        if (bus.A_out !== a || bus.B_out !== b) begin
            errors++;
            $display("FAIL %s_load: A=%h B=%h, required A=%h B=%h", name, bus.A_out, bus.B_out, a, b);
        end
        bus.Sub = sub; bus.Run = 1'b1;
        sb.push_back(model(a, b, sub));
        tick();
        finish_op(name, 4);
        bus.Run = 1'b0;
        tick();
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: Done=%b Busy=%b, required 0 0", name, bus.Done, bus.Busy);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #2;
        checks++;
        if (bus.Sum !== 16'h0000 || bus.CO !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 ||
            bus.A_out !== 16'h0000 || bus.B_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values: Sum=%h CO=%b Busy=%b Done=%b A=%h B=%h, required all 0",
                     bus.Sum, bus.CO, bus.Busy, bus.Done, bus.A_out, bus.B_out);
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        run_op(16'h0001, 16'h0002, 1'b0, "add_small");
        run_op(16'h1234, 16'h4321, 1'b0, "add_mixed");
    endtask

    task automatic test_carry_chain();
        load_ops(16'hFFFF, 16'h0001);
        bus.Sub = 1'b0; bus.Run = 1'b1;
        sb.push_back(model(16'hFFFF, 16'h0001, 1'b0));
        tick();
        tick();
        tick();
        checks++;
        if (bus.Sum !== 16'h0000 || dut.carry_q !== 1'b1 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL carry_mid: Sum=%h carry=%b Busy=%b, required 0000 1 1", bus.Sum, dut.carry_q, bus.Busy);
        end
        finish_op("carry_chain", 2);
        bus.Run = 1'b0;
        tick();
    endtask

    task automatic test_sub();
        run_op(16'h0005, 16'h0007, 1'b1, "sub_borrow");
        run_op(16'h0007, 16'h0005, 1'b1, "sub_noborrow");
        run_op(16'h0000, 16'h0000, 1'b1, "sub_zero");
    endtask

    task automatic test_run_hold();
        logic held_ok = 1'b1;
        load_ops(16'h0003, 16'h0004);
        bus.Sub = 1'b0; bus.Run = 1'b1;
        sb.push_back(model(16'h0003, 16'h0004, 1'b0));
        tick();
        finish_op("hold_first", 4);
        for (int i = 0; i < 10; i++) begin
            bus.Sub = 1'b1;
            tick();
            if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Sum !== 16'h0007) held_ok = 1'b0;
        end
        checks++;
        if (held_ok !== 1'b1) begin
            errors++;
            $display("FAIL hold_single_op: Done=%b Busy=%b Sum=%h, required 1 0 0007", bus.Done, bus.Busy, bus.Sum);
        end
        bus.Run = 1'b0;
        tick();
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: Done=%b Busy=%b, required 0 0", bus.Done, bus.Busy);
        end
        bus.Run = 1'b1;
        sb.push_back(model(16'h0003, 16'h0004, 1'b1));
        tick();
        finish_op("hold_rerun", 4);
        bus.Run = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        load_ops(16'h1111, 16'h2222);
        bus.Sub = 1'b0; bus.Run = 1'b1;
        tick();
        bus.Run = 1'b0; bus.LoadB = 1'b1; bus.LoadA = 1'b1; bus.SW = 16'h1234; bus.Sub = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.B_out !== 16'h2222 || bus.A_out !== 16'h1111 || bus.Sum !== 16'h0033 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL calc_frozen: A=%h B=%h Sum=%h Busy=%b, required 1111 2222 0033 1",
                     bus.A_out, bus.B_out, bus.Sum, bus.Busy);
        end
        bus.LoadA = 1'b0; bus.LoadB = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.Sum !== 16'h0000 || bus.CO !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 ||
            bus.A_out !== 16'h0000 || bus.B_out !== 16'h0000) begin
            errors++;
            $display("FAIL abort_async: Sum=%h CO=%b Busy=%b Done=%b A=%h B=%h, required all 0",
                     bus.Sum, bus.CO, bus.Busy, bus.Done, bus.A_out, bus.B_out);
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        run_op(16'h7FFF, 16'h0001, 1'b0, "ovf_add");
        run_op(16'h8000, 16'h0001, 1'b1, "ovf_sub");
    endtask

    task automatic test_single_slice();
        bus16.SW = 16'h7FFF; bus16.LoadA = 1'b1;
        tick();
        bus16.LoadA = 1'b0; bus16.SW = 16'h0001; bus16.LoadB = 1'b1;
        tick();
        bus16.LoadB = 1'b0; bus16.Sub = 1'b0; bus16.Run = 1'b1;
        tick();
        checks++;
        if (bus16.Busy !== 1'b1 || bus16.Done !== 1'b0) begin
            errors++;
            $display("FAIL s16_busy: Busy=%b Done=%b, required 1 0", bus16.Busy, bus16.Done);
        end
        tick();
        checks++;
        if (bus16.Done !== 1'b1 || bus16.Sum !== 16'h8000 || bus16.CO !== 1'b0) begin
            errors++;
            $display("FAIL s16_result: Done=%b Sum=%h CO=%b, required 1 8000 0", bus16.Done, bus16.Sum, bus16.CO);
        end
`ifdef SLICED_ADDER_OVF_EN
        checks++;
        if (bus16.V !== 1'b1) begin
            errors++;
            $display("FAIL s16_v: V=%b, required 1", bus16.V);
        end
`endif
        bus16.Run = 1'b0;
        tick();
    endtask

    initial begin
        bus.LoadA = 1'b0; bus.LoadB = 1'b0; bus.Run = 1'b0; bus.Sub = 1'b0; bus.SW = 16'h0000;
        bus16.LoadA = 1'b0; bus16.LoadB = 1'b0; bus16.Run = 1'b0; bus16.Sub = 1'b0; bus16.SW = 16'h0000;
        test_reset();
        test_add();
        test_carry_chain();
        test_sub();
        test_run_hold();
        test_abort();
        test_overflow();
        test_single_slice();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
